// File: rtl/iter_square.sv
// Sequential shift-add squarer: sq_out = x_ip * x_ip, one multiplier bit per clock.
// Optional SQ_OVF_EN adds ovf_out, set when the square does not fit in WIDTH bits.
module iter_square #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_ip,
  input  logic [WIDTH-1:0]   x_ip,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] sq_out
`ifdef SQ_OVF_EN
  ,
  output logic               ovf_out
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      sq_q, sq_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [PW-1:0]      sum_c;
  logic               last_c;
`ifdef SQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign sum_c  = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign last_c = (count_q == CNT_W'(WIDTH - 1));

  // State and datapath registers; reset overrides everything, including a run in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      count_q <= '0;
      sq_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      count_q <= count_d;
      sq_q    <= sq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ip) state_d = S_RUN;
      S_RUN:   if (last_c)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; done is a single-cycle pulse by default.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    count_d = count_q;
    sq_d    = sq_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ip) begin
          mcand_d = PW'(x_ip);
          mplr_d  = x_ip;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        acc_d   = sum_c;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + CNT_W'(1);
        if (last_c) begin
          sq_d   = sum_c;
          done_d = 1'b1;
          busy_d = 1'b0;
`ifdef SQ_OVF_EN
          ovf_d  = |sum_c[PW-1:WIDTH];
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign sq_out   = sq_q;
`ifdef SQ_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_iter_square.sv
// Self-checking bench for iter_square (WIDTH=16) against a plain x*x reference model.
module tb_iter_square;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_ip;
  logic [W-1:0]  x_ip;
  logic          busy_out;
  logic          done_out;
  logic [2*W-1:0] sq_out;
`ifdef SQ_OVF_EN
  logic          ovf_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_sq;

  always #5 clk = ~clk;

  iter_square #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_ip (start_ip),
    .x_ip     (x_ip),
    .busy_out (busy_out),
    .done_out (done_out),
    .sq_out   (sq_out)
`ifdef SQ_OVF_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  // One operation: start with x now, then watch every cycle until the completion cycle.
  task automatic do_op(input logic [W-1:0] x, input bit noise, input int inj_cyc,
                       input logic [W-1:0] inj_x);
    logic [2*W-1:0] want;
    want = (2*W)'(x) * (2*W)'(x);
    start_ip = 1'b1;
    x_ip     = x;
    for (int c = 0; c < int'(W); c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy_out !== 1'b1) begin
        errors++;
        $display("FAIL run_busy x=%h cyc=%0d got=%b want=1", x, c, busy_out);
      end
      checks++;
      if (done_out !== 1'b0) begin
        errors++;
        $display("FAIL run_done x=%h cyc=%0d got=%b want=0", x, c, done_out);
      end
      checks++;
      if (sq_out !== exp_sq) begin
        errors++;
        $display("FAIL run_hold x=%h cyc=%0d got=%h want=%h", x, c, sq_out, exp_sq);
      end
      start_ip = 1'b0;
      x_ip     = W'($urandom);
      if (noise) start_ip = 1'($urandom_range(0, 1));
      if (c == inj_cyc) begin
        start_ip = 1'b1;
        x_ip     = inj_x;
      end
    end
    @(posedge clk); #1;
    exp_sq = want;
    checks++;
    if (done_out !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse x=%h got=%b want=1", x, done_out);
    end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL done_busy x=%h got=%b want=0", x, busy_out);
    end
    checks++;
    if (sq_out !== want) begin
      errors++;
      $display("FAIL result x=%h got=%h want=%h", x, sq_out, want);
    end
`ifdef SQ_OVF_EN
    checks++;
    if (ovf_out !== (|want[2*W-1:W])) begin
      errors++;
      $display("FAIL ovf x=%h got=%b want=%b", x, ovf_out, |want[2*W-1:W]);
    end
`endif
    start_ip = 1'b0;
  endtask

  task automatic idle(input int n);
    start_ip = 1'b0;
    for (int i = 0; i < n; i++) begin
      x_ip = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (busy_out !== 1'b0 || done_out !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc=%0d busy=%b done=%b want 0/0", i, busy_out, done_out);
      end
      checks++;
      if (sq_out !== exp_sq) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, sq_out, exp_sq);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_ip = 1'b1;
    x_ip = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    exp_sq = '0;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b want 0/0", busy_out, done_out);
    end
    checks++;
    if (sq_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_sq got=%h want=00000000", sq_out);
    end
`ifdef SQ_OVF_EN
    checks++;
    if (ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got=%b want=0", ovf_out);
    end
`endif
    rst = 1'b0;
    start_ip = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    do_op(16'h0003, 1'b0, -1, '0);
    idle(2);
    do_op(16'h0000, 1'b0, -1, '0);
    idle(1);
    do_op(16'hFFFF, 1'b0, -1, '0);
    idle(1);
    do_op(16'h8000, 1'b0, -1, '0);
    idle(1);
  endtask

  task automatic test_ignored_start;
    do_op(16'h0005, 1'b0, 4, 16'h0007);
    idle(20);
  endtask

  task automatic test_back_to_back;
    do_op(16'h000A, 1'b0, -1, '0);
    do_op(16'h000B, 1'b0, -1, '0);
    idle(2);
  endtask

  task automatic test_reset_mid_run;
    start_ip = 1'b1;
    x_ip = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start_ip = 1'b0;
      x_ip = W'($urandom);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sq = '0;
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl busy=%b done=%b want 0/0", busy_out, done_out);
    end
    checks++;
    if (sq_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst_sq got=%h want=00000000", sq_out);
    end
    idle(20);
    do_op(16'h0102, 1'b0, -1, '0);
    idle(1);
  endtask

  task automatic test_ovf_edges;
    do_op(16'h00FF, 1'b0, -1, '0);
    do_op(16'h0100, 1'b0, -1, '0);
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      do_op(W'($urandom), 1'b1, -1, '0);
      idle(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b0;
    start_ip = 1'b0;
    x_ip = '0;
    exp_sq = '0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_ovf_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_square.md
Name: iter_square

Overview:
- Sequential shift-add squarer; the forward direction of the square-root datapath.
- Computes sq = x*x for an unsigned WIDTH-bit operand, one multiplier bit per clock.
- Used as the round-trip checker and reference generator for the root unit: square the root, compare against the radicand.
- Single start/done handshake; result held until the next completion.

Parameters:
- WIDTH, 16, operand width in bits (>= 2); result is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start_ip  input  1  request; sampled only in IDLE.
- x_ip  input  WIDTH  operand; captured on the accepted start edge only.
- busy_out  output  1  high while an operation is in RUN.
- done_out  output  1  one-cycle pulse when sq_out updates.
- sq_out  output  2*WIDTH  x*x of the last completed operation.
- ovf_out  output  1  present only with SQ_OVF_EN (see below).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy_out=0; done_out=0; sq_out=0; internal acc/mcand/mplr/count=0; ovf_out=0 if present.
  - Reset takes priority over every other event.
  - A reset mid-RUN abandons the operation; no done_out pulse follows.
- States: IDLE, RUN. No separate DONE state.
- IDLE, start_ip=1 at edge E0:
  - mcand <= {WIDTH zeros, x_ip}; mplr <= x_ip; acc <= 0; count <= 0.
  - state <= RUN; busy_out <= 1.
- IDLE, start_ip=0: hold all registers; done_out <= 0.
- RUN, each edge:
  - acc <= acc + (mplr[0] ? mcand : 0), sum on 2*WIDTH bits; cannot overflow.
  - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
- RUN, edge where count == WIDTH-1 (edge E0+WIDTH):
  - sq_out <= acc + (mplr[0] ? mcand : 0); done_out <= 1; busy_out <= 0; state <= IDLE.
- Latency: done_out is high in the cycle after edge E0+WIDTH, i.e. exactly WIDTH clocks after the accepted start. Fixed latency; no early exit for small operands.
- done_out is high for exactly one cycle; cleared on the next edge unless another completion occurs.
- start_ip while in RUN is ignored: not queued, x_ip not sampled.
- start_ip high in the cycle done_out is high (state already IDLE) is accepted, giving back-to-back throughput of one result per WIDTH clocks.
- sq_out changes only on completion edges or reset. Between completions it holds, including while a new operation runs.
- x_ip may change freely after E0 without affecting the result.

Optional Feature:
- Macro: SQ_OVF_EN.
- Defined:
  - Adds port ovf_out (output, 1).
  - On the completion edge, ovf_out <= |(final sum[2*WIDTH-1:WIDTH]), i.e. 1 when the square does not fit in WIDTH bits.
  - Updates with sq_out, holds between completions, reset to 0.
- Not defined: port and logic absent; sq_out behaviour identical.

Test Plan:
- WIDTH=16, reset then start with x_ip=0x0003: busy_out=1 for 16 cycles; done_out pulses once exactly 16 clocks after the start edge with sq_out=0x00000009. Repeat with x_ip=0: sq_out=0x00000000, still 16-cycle latency.
- x_ip=0xFFFF -> sq_out=0xFFFE0001. x_ip=0x8000 -> sq_out=0x40000000 (single-bit path).
- Start x_ip=0x0005; at cycle 4 assert start_ip with x_ip=0x0007: ignored. done at cycle 16 with sq_out=0x00000019. No second done pulse.
- Back-to-back: start 0x000A, assert start 0x000B during the done cycle -> sq_out=0x00000064, then 16 clocks later 0x00000079; sq_out holds 0x64 in between.
- Reset at cycle 8 of a run: busy_out=0, sq_out=0, no done pulse. A subsequent start with 0x0102 gives 0x00010404.
- SQ_OVF_EN defined: x_ip=0x00FF -> sq_out=0x0000FE01, ovf_out=0. x_ip=0x0100 -> sq_out=0x00010000, ovf_out=1.
